bpred_table_wr_sched: RTL and testbench
=======================================

# bpred_table_wr_sched

Write-port scheduler for the combined BTB/bimodal predictor table. It owns the table's single write port and sequences three write sources onto it:
- a power-up/reset clearing sweep;
- buffered execute-stage predictor updates;
- host/debug writes.

It sits between the execute-stage update logic and the table RAM, replacing the ad-hoc reset-index walk and direct update wiring.

## Interface
Parameters:
- INDEX_W, 9, table index width (2^INDEX_W entries).
- DATA_W, 36, table word width.
- FIFO_DEPTH, 4, update FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- stall  input  1  pipeline stall; blocks update FIFO drain only.
- upd_valid  input  1  execute-stage update request.
- upd_index  input  INDEX_W  table index (PC[10:2]).
- upd_data  input  DATA_W  write word.
- upd_byteen  input  4  byte enables (4'b0001 = bimodal-only, 4'b1111 = BTB+bimodal).
- upd_ready  output  1  FIFO can accept.
- host_valid  input  1  host write request.
- host_index  input  INDEX_W  host write index.
- host_data  input  DATA_W  host write word.
- host_byteen  input  4  host byte enables.
- host_ready  output  1  host write accepted this cycle when valid.
- mem_wren  output  1  table write enable (registered).
- mem_wraddr  output  INDEX_W  table write address (registered).
- mem_data  output  DATA_W  table write data (registered).
- mem_byteen  output  4  table byte enables (registered).
- init_busy  output  1  clearing sweep in progress.
- stat_sel  input  2  statistics select.
- stat_out  output  32  statistics value.

## Operation
States: INIT and RUN.

**Reset**
- State→INIT, sweep index→0, FIFO flushed (count 0, pointers 0), stats cleared.
- Outputs: mem_wren=0, mem_wraddr=0, mem_data=0, mem_byteen=0, init_busy=1, upd_ready=0, host_ready=0, stat_out=0.
- Reset asserted mid-sweep or mid-RUN does the same: sweep restarts at 0 and all queued updates are discarded.

**INIT**
- Each cycle issues a write with addr=sweep index, data=0, byteen=4'b1111, then increments the index.
- After issuing index 2^INDEX_W−1, state→RUN and init_busy→0 on the same edge.
- upd_ready=0 and host_ready=0 throughout INIT.

**RUN**
- upd_ready = (count != FIFO_DEPTH). It depends only on count; a pop in the same cycle does not open a slot.
- An enqueue happens when upd_valid && upd_ready.
- Arbitration per cycle, in priority order:
  1. If FIFO is non-empty and stall=0, pop the head and issue it.
  2. Otherwise, if host_valid, grant the host. host_ready = RUN && (count==0 || stall).
  3. Otherwise issue nothing (mem_wren=0).
- Simultaneous enqueue and pop: count unchanged.
- Updates to the same index retire in arrival order.
- A host write may overtake queued updates only while stall=1. This is intended, because stall freezes predictor updates.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.

## Timing
- An INIT write for index k appears on mem_* on the k+1'th edge after reset deasserts.
- RUN begins, and upd_ready can rise, 2^INDEX_W cycles after reset release.
- Host write handshaken in cycle N appears on mem_* in cycle N+1.
- Update enqueued in cycle N can be popped in cycle N+1 at the earliest and appears on mem_* in cycle N+2. There is no bypass.
- mem_wren is high for exactly one cycle per issued write.
- stat_out is combinational from stat_sel and the counters.

## Configuration
- BPRED_WRSCHED_STATS_EN
  - Defined: 32-bit wrapping counters exist.
    - stat_sel 0: updates enqueued.
    - stat_sel 1: host writes granted.
    - stat_sel 2: cycles with upd_valid && !upd_ready in RUN.
    - stat_sel 3: max FIFO occupancy seen.
  - Undefined: counters are not built and stat_out is tied to 0.

## Test plan
- Reset release, no traffic → 512 consecutive mem_wren pulses, addr 0..511, data 0, byteen 4'b1111. init_busy falls with the last one; upd_ready=1 on the next cycle.
- RUN, single update at index 9'h05, data 36'h123456789, byteen 4'b0001, stall=0 → mem_wren one cycle, exactly 2 cycles after the handshake, with matching addr, data and byteen.
- stall=1, push 5 updates, FIFO_DEPTH=4 → first 4 accepted, upd_ready=0 on the 5th, no mem_wren. Release stall → 4 writes on consecutive cycles in order; upd_ready rises one cycle after the first pop.
- FIFO holding 2 entries, stall=0, host_valid=1 → host_ready=0 until the FIFO drains. The host write then appears immediately after the 2 update writes. With stall=1 the host is granted at once.
- Reset asserted during RUN with 3 queued updates → no queued update is ever written; sweep restarts at address 0.
- With BPRED_WRSCHED_STATS_EN, after the stall scenario → stat_sel 0 = 4, stat_sel 2 ≥ 1, stat_sel 3 = 4. Without it → stat_out = 0 for every stat_sel.

Source files
------------

// File: rtl/bpred_table_wr_sched.sv
// bpred_table_wr_sched
// Owns the single write port of the combined BTB/bimodal predictor table and
// sequences three write sources onto it: the reset clearing sweep, buffered
// execute-stage updates (small FIFO), and host/debug writes.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall                      pipeline stall, freezes update FIFO drain only
//   upd_valid/index/data/byteen, upd_ready    execute-stage update request
//   host_valid/index/data/byteen, host_ready  host write request/grant
//   mem_wren/wraddr/data/byteen               registered table write port
//   init_busy                  clearing sweep in progress
//   stat_sel, stat_out         statistics select / combinational value
//
// Optional feature: define BPRED_WRSCHED_STATS_EN to build the statistics
// counters; otherwise stat_out is tied to zero.
module bpred_table_wr_sched #(
    parameter int INDEX_W    = 9,
    parameter int DATA_W     = 36,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [DATA_W-1:0]  upd_data,
    input  logic [3:0]         upd_byteen,
    output logic               upd_ready,
    input  logic               host_valid,
    input  logic [INDEX_W-1:0] host_index,
    input  logic [DATA_W-1:0]  host_data,
    input  logic [3:0]         host_byteen,
    output logic               host_ready,
    output logic               mem_wren,
    output logic [INDEX_W-1:0] mem_wraddr,
    output logic [DATA_W-1:0]  mem_data,
    output logic [3:0]         mem_byteen,
    output logic               init_busy,
    input  logic [1:0]         stat_sel,
    output logic [31:0]        stat_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [INDEX_W-1:0] LAST_IDX = '1;
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               r_state, w_state_nxt;
    logic [INDEX_W-1:0]   r_sweep, w_sweep_nxt;

    logic [INDEX_W-1:0]   r_fifo_idx  [FIFO_DEPTH];
    logic [DATA_W-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [3:0]           r_fifo_be   [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]       r_count, w_count_nxt;

    logic                 r_mem_wren,  w_wren_nxt;
    logic [INDEX_W-1:0]   r_mem_wraddr, w_addr_nxt;
    logic [DATA_W-1:0]    r_mem_data,  w_data_nxt;
    logic [3:0]           r_mem_byteen, w_be_nxt;

    logic w_run, w_push, w_pop, w_host_gnt;

    assign w_run      = (r_state == S_RUN);
    // Readiness looks at the registered count only: a same-cycle pop never
    // frees a slot for a same-cycle push.
    assign upd_ready  = w_run && (r_count != FULL_CNT);
    assign w_push     = upd_valid && upd_ready;
    assign w_pop      = w_run && (r_count != '0) && !stall;
    // Host gets the port whenever the FIFO would not drain this cycle; under
    // stall this lets host writes overtake frozen updates.
    assign host_ready = w_run && ((r_count == '0) || stall);
    assign w_host_gnt = host_valid && host_ready;
    assign init_busy  = !w_run;

    always_comb begin
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_wren_nxt  = 1'b0;
        w_addr_nxt  = r_mem_wraddr;
        w_data_nxt  = r_mem_data;
        w_be_nxt    = r_mem_byteen;
        unique case (r_state)
            S_INIT: begin
                w_wren_nxt  = 1'b1;
                w_addr_nxt  = r_sweep;
                w_data_nxt  = '0;
                w_be_nxt    = 4'b1111;
                w_sweep_nxt = r_sweep + 1'b1;
                if (r_sweep == LAST_IDX) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_pop) begin
                    w_wren_nxt = 1'b1;
                    w_addr_nxt = r_fifo_idx[r_rd_ptr];
                    w_data_nxt = r_fifo_data[r_rd_ptr];
                    w_be_nxt   = r_fifo_be[r_rd_ptr];
                end else if (w_host_gnt) begin
                    w_wren_nxt = 1'b1;
                    w_addr_nxt = host_index;
                    w_data_nxt = host_data;
                    w_be_nxt   = host_byteen;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sweep      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_mem_wren   <= 1'b0;
            r_mem_wraddr <= '0;
            r_mem_data   <= '0;
            r_mem_byteen <= '0;
        end else begin
            r_sweep      <= w_sweep_nxt;
            r_count      <= w_count_nxt;
            r_mem_wren   <= w_wren_nxt;
            r_mem_wraddr <= w_addr_nxt;
            r_mem_data   <= w_data_nxt;
            r_mem_byteen <= w_be_nxt;
            // Pointer width equals log2(depth), so increments wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage needs no reset: the count decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr]  <= upd_index;
            r_fifo_data[r_wr_ptr] <= upd_data;
            r_fifo_be[r_wr_ptr]   <= upd_byteen;
        end
    end

    assign mem_wren   = r_mem_wren;
    assign mem_wraddr = r_mem_wraddr;
    assign mem_data   = r_mem_data;
    assign mem_byteen = r_mem_byteen;

`ifdef BPRED_WRSCHED_STATS_EN
    logic [31:0] r_stat_enq, r_stat_host, r_stat_full, r_stat_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_enq  <= '0;
            r_stat_host <= '0;
            r_stat_full <= '0;
            r_stat_max  <= '0;
        end else begin
            if (w_push)                          r_stat_enq  <= r_stat_enq + 1'b1;
            if (w_host_gnt)                      r_stat_host <= r_stat_host + 1'b1;
            if (w_run && upd_valid && !upd_ready) r_stat_full <= r_stat_full + 1'b1;
            // Track the post-edge occupancy so the maximum is current at once.
            if (32'(w_count_nxt) > r_stat_max)   r_stat_max  <= 32'(w_count_nxt);
        end
    end

    always_comb begin
        stat_out = '0;
        unique case (stat_sel)
            2'd0:    stat_out = r_stat_enq;
            2'd1:    stat_out = r_stat_host;
            2'd2:    stat_out = r_stat_full;
            default: stat_out = r_stat_max;
        endcase
    end
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel;
    assign stat_out = '0;
`endif

endmodule

// File: tb/tb_bpred_table_wr_sched.sv
module tb_bpred_table_wr_sched;

    localparam int IW    = 9;
    localparam int DW    = 36;
    localparam int DEPTH = 4;
    localparam int NENT  = 1 << IW;

    logic          clk;
    logic          reset, stall, upd_valid, host_valid;
    logic [IW-1:0] upd_index, host_index;
    logic [DW-1:0] upd_data, host_data;
    logic [3:0]    upd_byteen, host_byteen;
    logic          upd_ready, host_ready, mem_wren, init_busy;
    logic [IW-1:0] mem_wraddr;
    logic [DW-1:0] mem_data;
    logic [3:0]    mem_byteen;
    logic [1:0]    stat_sel;
    logic [31:0]   stat_out;

    bpred_table_wr_sched #(.INDEX_W(IW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_data(upd_data),
        .upd_byteen(upd_byteen), .upd_ready(upd_ready),
        .host_valid(host_valid), .host_index(host_index), .host_data(host_data),
        .host_byteen(host_byteen), .host_ready(host_ready),
        .mem_wren(mem_wren), .mem_wraddr(mem_wraddr), .mem_data(mem_data),
        .mem_byteen(mem_byteen), .init_busy(init_busy),
        .stat_sel(stat_sel), .stat_out(stat_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            wren;
        logic [IW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    be;
    } wr_t;

    wr_t sb[$];   // expected mem_* per cycle, one entry per clock edge
    wr_t mq[$];   // reference model of the update queue

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit  m_known = 0;
    bit  m_run   = 0;
    int  m_sweep = 0;
    int  m_enq = 0, m_host = 0, m_full = 0, m_max = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mem_wren", {63'd0, mem_wren}, {63'd0, e.wren});
                if (e.wren && mem_wren) begin
                    chk("mem_wraddr", 64'(mem_wraddr), 64'(e.addr));
                    chk("mem_data",   64'(mem_data),   64'(e.data));
                    chk("mem_byteen", 64'(mem_byteen), 64'(e.be));
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, check handshakes against the model,
    // predict this edge's write, then advance the model across the edge.
    task automatic step(input bit rst_i, input bit st, input bit uv,
                        input logic [IW-1:0] ui, input logic [DW-1:0] ud, input logic [3:0] ub,
                        input bit hv, input logic [IW-1:0] hi, input logic [DW-1:0] hd,
                        input logic [3:0] hb, output bit hg);
        wr_t pred, ent;
        bit exp_ur, exp_hr, pop, push;
        reset = rst_i; stall = st;
        upd_valid = uv; upd_index = ui; upd_data = ud; upd_byteen = ub;
        host_valid = hv; host_index = hi; host_data = hd; host_byteen = hb;
        #2;
        exp_ur = m_run && (mq.size() != DEPTH);
        exp_hr = m_run && (mq.size() == 0 || st);
        if (m_known) begin
            chk("upd_ready",  {63'd0, upd_ready},  {63'd0, exp_ur});
            chk("host_ready", {63'd0, host_ready}, {63'd0, exp_hr});
            chk("init_busy",  {63'd0, init_busy},  {63'd0, !m_run});
        end
        pred.wren = 0; pred.addr = '0; pred.data = '0; pred.be = '0;
        hg = 0; pop = 0; push = 0;
        if (!rst_i) begin
            if (!m_run) begin
                pred.wren = 1; pred.addr = m_sweep[IW-1:0]; pred.be = 4'b1111;
            end else begin
                pop  = (mq.size() > 0) && !st;
                push = uv && exp_ur;
                if (pop) begin
                    pred = mq[0]; pred.wren = 1;
                end else if (hv && exp_hr) begin
                    pred.wren = 1; pred.addr = hi; pred.data = hd; pred.be = hb; hg = 1;
                end
            end
        end
        @(posedge clk);
        if (rst_i) begin
            m_known = 1; m_run = 0; m_sweep = 0; mq.delete();
            m_enq = 0; m_host = 0; m_full = 0; m_max = 0;
        end else if (!m_run) begin
            m_sweep++;
            if (m_sweep == NENT) m_run = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                ent.wren = 1; ent.addr = ui; ent.data = ud; ent.be = ub;
                mq.push_back(ent);
                m_enq++;
            end
            if (hg) m_host++;
            if (uv && !exp_ur) m_full++;
            if (mq.size() > m_max) m_max = mq.size();
        end
        #1;
        sb.push_back(pred);
    endtask

    task automatic idle(input int n, input bit st);
        bit hg;
        for (int i = 0; i < n; i++) step(0, st, 0, '0, '0, '0, 0, '0, '0, '0, hg);
    endtask

    task automatic push_upd(input bit st, input logic [IW-1:0] idx, input logic [DW-1:0] d,
                            input logic [3:0] be);
        bit hg;
        step(0, st, 1, idx, d, be, 0, '0, '0, '0, hg);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic check_stats();
        logic [31:0] exp;
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
`ifdef BPRED_WRSCHED_STATS_EN
            case (s)
                0: exp = 32'(m_enq);
                1: exp = 32'(m_host);
                2: exp = 32'(m_full);
                default: exp = 32'(m_max);
            endcase
`else
            exp = '0;
`endif
            chk($sformatf("stat_out[%0d]", s), 64'(stat_out), 64'(exp));
        end
    endtask

    initial begin
        bit hg;
        int n;
        logic [DW-1:0] hd;
        stat_sel = 2'd0;
        fork
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog expired at %0t", $time);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset, then check the documented reset values.
        step(1, 0, 0, '0, '0, '0, 0, '0, '0, '0, hg);
        step(1, 0, 0, '0, '0, '0, 0, '0, '0, '0, hg);
        chk("rst_mem_wren",   {63'd0, mem_wren}, 64'd0);
        chk("rst_mem_wraddr", 64'(mem_wraddr), 64'd0);
        chk("rst_mem_data",   64'(mem_data), 64'd0);
        chk("rst_mem_byteen", 64'(mem_byteen), 64'd0);
        chk("rst_init_busy",  {63'd0, init_busy}, 64'd1);
        chk("rst_upd_ready",  {63'd0, upd_ready}, 64'd0);
        chk("rst_host_ready", {63'd0, host_ready}, 64'd0);
        check_stats();

        // Clearing sweep with no traffic (requests during INIT must be ignored
        // for the first few cycles too).
        step(0, 0, 1, 9'h1, 36'h1, 4'hf, 1, 9'h2, 36'h2, 4'hf, hg);
        idle(NENT - 1, 0);
        chk("run_reached", {63'd0, m_run}, 64'd1);
        idle(2, 0);

        // Single update: write appears two cycles after the handshake.
        push_upd(0, 9'h05, 36'h123456789, 4'b0001);
        idle(4, 0);

        // Stall with 5 pushes: 4 accepted, 5th refused, then drain in order.
        for (int i = 0; i < 5; i++) push_upd(1, 9'($urandom), rnd_data(), 4'(i));
        idle(2, 1);
        idle(6, 0);
        check_stats();

        // Two queued, no stall: host waits for drain, then writes right after.
        push_upd(1, 9'h10, 36'haaaa, 4'b1111);
        push_upd(1, 9'h11, 36'hbbbb, 4'b0001);
        n = 0; hg = 0;
        while (!hg && n < 20) begin
            step(0, 0, 0, '0, '0, '0, 1, 9'h1ff, 36'hc0ffee, 4'b0011, hg);
            n++;
        end
        chk("host_wait_cycles", 64'(n), 64'd3);
        idle(3, 0);

        // Two queued under stall: host is granted at once.
        push_upd(1, 9'h20, 36'h1111, 4'b1111);
        push_upd(1, 9'h21, 36'h2222, 4'b1111);
        step(0, 1, 0, '0, '0, '0, 1, 9'h022, 36'h3333, 4'b1000, hg);
        chk("host_stall_grant", {63'd0, hg}, 64'd1);
        idle(4, 0);
        check_stats();

        // Randomized traffic, including same-index bursts.
        for (int i = 0; i < 1500; i++) begin
            hd = rnd_data();
            step(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 9'($urandom_range(0, 7)), rnd_data(), 4'($urandom),
                 $urandom_range(0, 3) == 0, 9'($urandom), hd, 4'($urandom), hg);
        end
        idle(6, 0);
        check_stats();

        // Reset with 3 queued updates: nothing queued is ever written.
        for (int i = 0; i < 3; i++) push_upd(1, 9'(100 + i), rnd_data(), 4'b1111);
        step(1, 1, 0, '0, '0, '0, 0, '0, '0, '0, hg);
        step(1, 0, 0, '0, '0, '0, 0, '0, '0, '0, hg);
        check_stats();
        idle(NENT + 3, 0);
        push_upd(0, 9'h1aa, 36'hfedcba987, 4'b1111);
        idle(4, 0);
        check_stats();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
